// File: rtl/alu_pkg.sv
// Shared definitions for the ALU/register-file slice: default widths and opcode encodings.
package alu_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 3;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_ADC   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_SBC   = 4'b0011;
    localparam logic [3:0] OP_AND   = 4'b0100;
    localparam logic [3:0] OP_OR    = 4'b0101;
    localparam logic [3:0] OP_XOR   = 4'b0110;
    localparam logic [3:0] OP_NOT   = 4'b0111;
    localparam logic [3:0] OP_SHL   = 4'b1000;
    localparam logic [3:0] OP_SHR   = 4'b1001;
    localparam logic [3:0] OP_ASR   = 4'b1010;
    localparam logic [3:0] OP_ROL   = 4'b1011;
    localparam logic [3:0] OP_ROR   = 4'b1100;
    localparam logic [3:0] OP_INC   = 4'b1101;
    localparam logic [3:0] OP_DEC   = 4'b1110;
    localparam logic [3:0] OP_PASSB = 4'b1111;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result plus zero/carry/overflow/negative flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        opcode,
    input  logic              cin,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry,
    output logic              overflow,
    output logic              negative
);

    localparam int MSB = DATA_W - 1;
    localparam logic [DATA_W:0] ONE = (DATA_W + 1)'(1);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] cin_ext;

    assign cin_ext = {{DATA_W{1'b0}}, cin};

    always_comb begin
        sum      = '0;
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (opcode)
            OP_ADD, OP_ADC: begin
                sum      = {1'b0, a} + {1'b0, b} + ((opcode == OP_ADC) ? cin_ext : '0);
                result   = sum[MSB:0];
                carry    = sum[DATA_W];
                overflow = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
            end
            OP_SUB, OP_SBC: begin
                // Top bit of the 9-bit difference is the borrow.
                sum      = {1'b0, a} - {1'b0, b} - ((opcode == OP_SBC) ? cin_ext : '0);
                result   = sum[MSB:0];
                carry    = sum[DATA_W];
                overflow = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin
                result = {a[MSB-1:0], 1'b0};
                carry  = a[MSB];
            end
            OP_SHR: begin
                result = {1'b0, a[MSB:1]};
                carry  = a[0];
            end
            OP_ASR: begin
                result = {a[MSB], a[MSB:1]};
                carry  = a[0];
            end
            OP_ROL: begin
                result = {a[MSB-1:0], a[MSB]};
                carry  = a[MSB];
            end
            OP_ROR: begin
                result = {a[0], a[MSB:1]};
                carry  = a[0];
            end
            OP_INC: begin
                sum      = {1'b0, a} + ONE;
                result   = sum[MSB:0];
                carry    = sum[DATA_W];
                overflow = !a[MSB] && result[MSB];
            end
            OP_DEC: begin
                sum      = {1'b0, a} - ONE;
                result   = sum[MSB:0];
                carry    = sum[DATA_W];
                overflow = a[MSB] && !result[MSB];
            end
            default: result = b;
        endcase
    end

    assign zero     = (result == '0);
    assign negative = result[MSB];

endmodule

// File: rtl/alu_regfile.sv
// Execute-stage slice: 8x8 register file (2 async read ports, 1 sync write port) feeding the ALU.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write_en,
    input  logic [3:0]        opcode,
    input  logic              cin,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry,
    output logic              overflow,
    output logic              negative
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // No write-through bypass: a same-cycle read sees the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (write_en) begin
            regs_q[write_reg] <= write_data;
        end
    end

    assign read_data1 = regs_q[read_reg1];
    assign read_data2 = regs_q[read_reg2];

    alu_core #(
        .DATA_W(DATA_W)
    ) u_alu_core (
        .a       (read_data1),
        .b       (read_data2),
        .opcode  (opcode),
        .cin     (cin),
        .result  (result),
        .zero    (zero),
        .carry   (carry),
        .overflow(overflow),
        .negative(negative)
    );

endmodule

// File: tb/tb_alu_regfile.sv
// Self-checking bench for alu_regfile: directed plan steps plus randomized traffic vs. an integer model.
module tb_alu_regfile;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] read_reg1, read_reg2, write_reg;
    logic [7:0] write_data;
    logic       write_en;
    logic [3:0] opcode;
    logic       cin;
    logic [7:0] read_data1, read_data2, result;
    logic       zero, carry, overflow, negative;

    int passed = 0;
    int total  = 0;
    int model [8];

    always #5 clk = ~clk;

    alu_regfile dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .read_reg1 (read_reg1),
        .read_reg2 (read_reg2),
        .write_reg (write_reg),
        .write_data(write_data),
        .write_en  (write_en),
        .opcode    (opcode),
        .cin       (cin),
        .read_data1(read_data1),
        .read_data2(read_data2),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .negative  (negative)
    );

    // Reference: {result, Z, C, V, N} from plain integer arithmetic.
    function automatic logic [11:0] ref_alu(input int a, input int b, input int op, input int ci);
        int sa, sb, r, s;
        bit c, v;
        logic [7:0] r8;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        c = 0;
        v = 0;
        s = 0;
        case (op)
            0:  begin r = a + b;      c = (r > 255); s = sa + sb;      v = (s > 127 || s < -128); end
            1:  begin r = a + b + ci; c = (r > 255); s = sa + sb + ci; v = (s > 127 || s < -128); end
            2:  begin r = a - b;      c = (r < 0);   s = sa - sb;      v = (s > 127 || s < -128); end
            3:  begin r = a - b - ci; c = (r < 0);   s = sa - sb - ci; v = (s > 127 || s < -128); end
            4:  r = a & b;
            5:  r = a | b;
            6:  r = a ^ b;
            7:  r = 255 - a;
            8:  begin r = a * 2;                  c = (a >= 128);  end
            9:  begin r = a / 2;                  c = (a % 2 == 1); end
            10: begin r = (sa - (a % 2)) / 2;     c = (a % 2 == 1); end
            11: begin r = a * 2 + a / 128;        c = (a >= 128);  end
            12: begin r = a / 2 + (a % 2) * 128;  c = (a % 2 == 1); end
            13: begin r = a + 1; c = (r > 255); s = sa + 1; v = (s > 127); end
            14: begin r = a - 1; c = (r < 0);   s = sa - 1; v = (s < -128); end
            default: r = b;
        endcase
        r  = ((r % 256) + 256) % 256;
        r8 = r[7:0];
        return {r8, (r == 0), c, v, r8[7]};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic do_write(input int addr, input int data);
        @(negedge clk);
        write_en   = 1'b1;
        write_reg  = addr[2:0];
        write_data = data[7:0];
        @(posedge clk);
        #1;
        write_en   = 1'b0;
        model[addr] = data;
    endtask

    task automatic check_alu(input string tag, input int r1, input int r2, input int op,
                             input int ci);
        @(negedge clk);
        read_reg1 = r1[2:0];
        read_reg2 = r2[2:0];
        opcode    = op[3:0];
        cin       = ci[0];
        #1;
        chk({tag, "_rd1"}, 16'(read_data1), 16'(model[r1]));
        chk({tag, "_rd2"}, 16'(read_data2), 16'(model[r2]));
        chk({tag, "_alu"}, 16'({result, zero, carry, overflow, negative}),
            16'(ref_alu(model[r1], model[r2], op, ci)));
    endtask

    initial begin
        rst_n = 1'b1;
        read_reg1 = '0; read_reg2 = '0; write_reg = '0; write_data = '0;
        write_en = 1'b0; opcode = 4'h0; cin = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_held", 16'({read_data1, zero, carry, overflow, negative}), 16'({8'h00, 4'b1000}));
        chk("reset_res", 16'({read_data2, result}), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        check_alu("rst_add", 0, 1, 0, 0);

        do_write(0, 8'hAA);
        check_alu("aa_add", 0, 1, 0, 0);
        chk("aa_const", 16'({result, zero, carry, overflow, negative}), 16'({8'hAA, 4'b0001}));

        // Read-during-write on r1: old value before the edge, new value after.
        @(negedge clk);
        read_reg2 = 3'd1; write_reg = 3'd1; write_data = 8'h55; write_en = 1'b1;
        #1;
        chk("rdw_before", 16'(read_data2), 16'h0000);
        @(posedge clk);
        #1;
        write_en = 1'b0;
        model[1] = 8'h55;
        chk("rdw_after", 16'(read_data2), 16'h0055);
        check_alu("ff_add", 0, 1, 0, 0);
        chk("ff_const", 16'({result, zero, carry, overflow, negative}), 16'({8'hFF, 4'b0001}));

        do_write(2, 8'h7F);
        do_write(3, 8'h01);
        check_alu("ovf_add", 2, 3, 0, 0);
        chk("ovf_const", 16'({result, zero, carry, overflow, negative}), 16'({8'h80, 4'b0011}));
        do_write(2, 8'hFF);
        check_alu("wrap_add", 2, 3, 0, 0);
        chk("wrap_const", 16'({result, zero, carry, overflow, negative}), 16'({8'h00, 4'b1100}));

        do_write(2, 8'h01);
        do_write(3, 8'h02);
        check_alu("borrow_sub", 2, 3, 2, 0);
        chk("borrow_const", 16'({result, zero, carry, overflow, negative}), 16'({8'hFF, 4'b0101}));
        do_write(4, 8'h81);
        check_alu("shl", 4, 0, 8, 0);
        chk("shl_const", 16'({result, carry}), 16'({8'h02, 1'b1}));
        check_alu("ror", 2, 0, 12, 0);
        chk("ror_const", 16'({result, carry}), 16'({8'h80, 1'b1}));

        // Async reset mid-cycle, with a write pending while reset is held.
        do_write(5, 8'h33);
        check_alu("r5_pass", 5, 5, 15, 0);
        @(negedge clk);
        opcode = 4'h0; cin = 1'b0; read_reg1 = 3'd5; read_reg2 = 3'd5;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) model[i] = 0;
        chk("async_rst", 16'({read_data1, read_data2}), 16'h0000);
        chk("async_flags", 16'({result, zero, carry, overflow, negative}), 16'({8'h00, 4'b1000}));
        write_en = 1'b1; write_reg = 3'd5; write_data = 8'hEE;
        @(posedge clk);
        #1;
        chk("rst_blocks_wr", 16'(read_data1), 16'h0000);
        @(negedge clk);
        write_en = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) check_alu("post_rst", i, (i + 1) % 8, 0, 0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 1) == 1) do_write($urandom_range(0, 7), $urandom_range(0, 255));
            check_alu("rand", $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 15),
                      $urandom_range(0, 1));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_regfile.md
Name: alu_regfile

Overview:
- 8-bit datapath slice: an 8-entry x 8-bit register file with two combinational read ports and one synchronous write port.
- Read port 1 drives ALU operand a; read port 2 drives ALU operand b.
- The ALU is purely combinational and produces the result plus Z/C/V/N flags.
- Sits in the CPU execute stage; the result is written back externally through the write port.

Parameters:
- DATA_W, 8, datapath and register width.
- ADDR_W, 3, register address width; NUM_REGS = 2**ADDR_W = 8.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- read_reg1  input  ADDR_W  register index for operand a.
- read_reg2  input  ADDR_W  register index for operand b.
- write_reg  input  ADDR_W  destination register index.
- write_data  input  DATA_W  write value.
- write_en  input  1  write strobe, sampled on the rising edge of clk.
- opcode  input  4  ALU operation select.
- cin  input  1  carry/borrow in (ADC/SBC only).
- read_data1  output  DATA_W  contents of read_reg1 (= operand a).
- read_data2  output  DATA_W  contents of read_reg2 (= operand b).
- result  output  DATA_W  ALU result.
- zero  output  1  result == 0.
- carry  output  1  carry / borrow / shifted-out bit.
- overflow  output  1  signed overflow.
- negative  output  1  result[DATA_W-1].

Behaviour:
- Reset:
  - rst_n low immediately clears all 8 registers to 0x00, independent of clk.
  - While reset is held: read_data1 = read_data2 = 0x00. With opcode ADD and cin = 0: result = 0x00, zero = 1, carry = overflow = negative = 0.
- Write:
  - On a rising clk edge with rst_n high and write_en = 1, regs[write_reg] <= write_data.
  - All registers, including r0, are writable. There is no hard-wired zero register.
- Read: combinational, with zero-cycle latency from read_reg or register contents to read_data.
- Read-during-write: before the edge a read returns the old value; the new value appears immediately after the edge. There is no write-through bypass.
- ALU: combinational, zero latency. a = read_data1, b = read_data2. Flags are computed from the 8-bit result.
- Opcodes (the opcode value follows each name):
  - ADD 0000: a+b; C = carry out; V = signed overflow.
  - ADC 0001: a+b+cin; C and V as for ADD.
  - SUB 0010: a-b; C = borrow (1 when a<b unsigned); V = signed overflow.
  - SBC 0011: a-b-cin; C = borrow; V = signed overflow.
  - AND 0100, OR 0101, XOR 0110, NOT 0111 (~a): C = V = 0.
  - SHL 1000: a<<1; C = a[7].
  - SHR 1001: logical right; C = a[0].
  - ASR 1010: arithmetic right; C = a[0].
  - ROL 1011: rotate left; C = a[7].
  - ROR 1100: rotate right; C = a[0].
  - Shift/rotate ops: V = 0.
  - INC 1101: a+1; C and V as ADD with b = 1.
  - DEC 1110: a-1; C and V as SUB with b = 1.
  - PASSB 1111: result = b; C = V = 0.
- Flags valid for every opcode: Z = (result==0); N = result[7].
- Arithmetic is mod 256; wrap-around is reported only via the C and V flags.
- Reset asserted mid-write: reset wins and the pending write is discarded.

Decomposition:
- Shared package alu_pkg: opcode localparams (OP_ADD … OP_PASSB) and DATA_W/ADDR_W defaults.
- Sub-module alu_core: the combinational ALU, kept separate so it can be reused and unit-tested.
- The register array and read muxes live in the top level.

Test Plan:
- Reset, then read r0/r1 with ADD -> read_data1 = read_data2 = 0x00, result = 0x00, Z=1, C=V=N=0.
- Write 0xAA to r0; read r0,r1 with ADD -> a=0xAA, b=0x00, result=0xAA, N=1, Z=C=V=0.
- Then write 0x55 to r1; ADD -> result=0xFF, N=1, Z=C=V=0. Before the edge, read_data2 still reads 0x00.
- r2=0x7F, r3=0x01, ADD -> 0x80, V=1, N=1, C=0. Then r2=0xFF, r3=0x01, ADD -> 0x00, Z=1, C=1, V=0.
- SUB with r2=0x01, r3=0x02 -> 0xFF, C=1 (borrow), N=1. SHL on a=0x81 -> 0x02, C=1. ROR on a=0x01 -> 0x80, C=1.
- Write r5=0x33, then pulse rst_n low between clock edges -> all outputs go to 0x00 at once. write_en=1 while rst_n is low -> no register changes.
